seq_magnitude_comparator: RTL and testbench

Parametrised, multi-cycle magnitude comparator for the ALU compare path. It replaces the fixed 3-bit combinational comparator with a WIDTH-bit, chunk-serial engine. It scans operands MSB-first, CHUNK bits per cycle, and supports both signed and unsigned modes. Operands arrive on a valid/ready input channel and one-hot gt/lt/eq flags are returned on a valid/ready output channel, so the block can sit between the operand register file and the flag/branch logic without a combinational path.

---
 rtl/seq_magnitude_comparator.sv | 157 +++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : seq_magnitude_comparator
// Brief    : Chunk-serial MSB-first signed/unsigned magnitude comparator with
//            valid/ready handshakes. Define CMP_EARLY_EXIT_EN for early exit.
// Revision : 1.0 - initial release
// ============================================================================
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_signed;
    logic [IDXW-1:0]   r_idx;
    logic              r_gt;
    logic              r_lt;
    logic              r_eq;

    logic [CHUNK-1:0]  w_ca;
    logic [CHUNK-1:0]  w_cb;
    logic              w_top;
    logic              w_last;
    logic              w_sign_diff;
    logic              w_gt;
    logic              w_lt;
    logic              w_exit;
    logic              w_res_gt;
    logic              w_res_lt;

    always_comb begin
        w_ca = '0;
        w_cb = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_ca = r_a[i*CHUNK +: CHUNK];
                w_cb = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    assign w_top       = (r_idx == IDXW'(NCHUNK - 1));
    assign w_last      = (r_idx == '0);
    // In signed mode a differing sign bit settles the result on its own.
    assign w_sign_diff = r_signed & w_top & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_gt        = w_sign_diff ? r_b[WIDTH-1] : (w_ca > w_cb);
    assign w_lt        = w_sign_diff ? r_a[WIDTH-1] : (w_ca < w_cb);

`ifdef CMP_EARLY_EXIT_EN
    assign w_exit   = w_last | w_gt | w_lt;
    assign w_res_gt = w_gt;
    assign w_res_lt = w_lt;
`else
    logic r_decided;
    logic r_dgt;
    logic r_dlt;

    assign w_exit   = w_last;
    assign w_res_gt = r_decided ? r_dgt : w_gt;
    assign w_res_lt = r_decided ? r_dlt : w_lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_decided <= 1'b0;
            r_dgt     <= 1'b0;
            r_dlt     <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_decided <= 1'b0;
            r_dgt     <= 1'b0;
            r_dlt     <= 1'b0;
        end else if (r_state == S_CMP && !r_decided && (w_gt || w_lt)) begin
            r_decided <= 1'b1;
            r_dgt     <= w_gt;
            r_dlt     <= w_lt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_CMP;
            S_CMP:   if (w_exit)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_a      <= a;
                r_b      <= b;
                r_signed <= signed_mode;
                r_idx    <= IDXW'(NCHUNK - 1);
            end else if (r_state == S_CMP) begin
                if (w_exit) begin
                    // Flags only change here so they stay readable after the handshake.
                    r_gt <= w_res_gt;
                    r_lt <= w_res_lt;
                    r_eq <= ~(w_res_gt | w_res_lt);
                end else begin
                    r_idx <= r_idx - IDXW'(1);
                end
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign gt        = r_gt;
    assign lt        = r_lt;
    assign eq        = r_eq;

endmodule
`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
`default_nettype none
// Directed table-driven bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4).
module tb_seq_magnitude_comparator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic        gt;
    logic        lt;
    logic        eq;

    int n_pass;
    int n_total;

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gt         (gt),
        .lt         (lt),
        .eq         (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        sgn;
        logic [2:0]  flags;   // {gt, lt, eq}
        int          lat_early;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int exp_lat(input int early);
`ifdef CMP_EARLY_EXIT_EN
        return early;
`else
        return 4;
`endif
    endfunction

    // Accept operands, wait for the result, check latency/flags, then hand-shake.
    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
        a = vecs[i].va; b = vecs[i].vb; signed_mode = vecs[i].sgn; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].lat_early));
        chk($sformatf("v%0d_flags", i), {29'b0, gt, lt, eq}, {29'b0, vecs[i].flags});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d_ready_after_hs", i), {30'b0, in_ready, out_valid}, 32'b10);
        chk($sformatf("v%0d_flags_held", i), {29'b0, gt, lt, eq}, {29'b0, vecs[i].flags});
    endtask

    initial begin
        int lat;
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0;

        vecs[0]  = '{16'h1234, 16'h1234, 1'b0, 3'b001, 4};
        vecs[1]  = '{16'h8000, 16'h0001, 1'b0, 3'b100, 1};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b1, 3'b010, 1};
        vecs[3]  = '{16'hFFFE, 16'hFFFF, 1'b1, 3'b010, 4};
        vecs[4]  = '{16'h1235, 16'h1234, 1'b0, 3'b100, 4};
        vecs[5]  = '{16'h1234, 16'h1235, 1'b0, 3'b010, 4};
        vecs[6]  = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1};
        vecs[7]  = '{16'h0100, 16'h0200, 1'b0, 3'b010, 2};
        vecs[8]  = '{16'h0030, 16'h0020, 1'b0, 3'b100, 3};
        vecs[9]  = '{16'hFFFF, 16'h0000, 1'b1, 3'b010, 1};
        vecs[10] = '{16'h8000, 16'h8000, 1'b1, 3'b001, 4};
        vecs[11] = '{16'h1000, 16'h0FFF, 1'b1, 3'b100, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {28'b0, in_ready, out_valid, gt, lt, eq} , 32'b10000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i);

        // Backpressure: result must hold, and a new in_valid in DONE must wait.
        @(negedge clk);
        a = 16'h8000; b = 16'h0001; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h0001; b = 16'h8000;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk("bp_latency", lat, exp_lat(1));
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", c), {27'b0, out_valid, in_ready, gt, lt, eq}, 32'b10100);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accepted", {31'b0, in_ready}, 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk("bp_next_latency", lat, exp_lat(1));
        chk("bp_next_flags", {29'b0, gt, lt, eq}, 32'b010);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a compare.
        @(negedge clk);
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {28'b0, in_ready, out_valid, gt, lt, eq}, 32'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", {31'b0, in_ready}, 32'd1);
        run_vec(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
